// File: rtl/framing_ctrl.sv
// Receive-side PCIe framing controller: delimits TLP/DLLP packets and COM-led ordered sets.
// Optional FRAMING_CTRL_STATS_EN adds saturating good/bad packet counters.
module framing_ctrl #(
    parameter int MAX_LEN  = 64,
    parameter int DLLP_LEN = 6
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        sym_valid,
    input  logic [3:0]  sym_type,
    input  logic [7:0]  sym_data,
    output logic        pkt_valid,
    output logic [7:0]  pkt_data,
    output logic        pkt_sop,
    output logic        pkt_eop,
    output logic        pkt_abort,
    output logic        pkt_dllp,
    output logic        skp_os,
    output logic [2:0]  skp_count,
    output logic        fts_seen,
    output logic        frame_err,
    output logic        link_idle,
    output logic [15:0] good_cnt,
    output logic [15:0] bad_cnt
);
    localparam int LW = $clog2(MAX_LEN + 1);
    localparam logic [LW-1:0] TLP_LIM  = LW'(MAX_LEN);
    localparam logic [LW-1:0] DLLP_LIM = LW'(DLLP_LEN);

    localparam logic [1:0] S_IDLE = 2'd0, S_TLP = 2'd1, S_DLLP = 2'd2, S_OS = 2'd3;
    localparam logic [3:0] T_DATA = 4'd0, T_COM = 4'd1, T_PAD = 4'd2, T_SKP = 4'd3,
                           T_STP  = 4'd4, T_SDP = 4'd5, T_END = 4'd6, T_EDB = 4'd7,
                           T_FTS  = 4'd8, T_IDL = 4'd9;

    logic [1:0]    state_q, state_d;
    logic [7:0]    hold_q, hold_d;
    logic          hold_full_q, hold_full_d, first_q, first_d;
    logic [LW-1:0] len_q, len_d, lim;
    logic [2:0]    skp_q, skp_d, skp_cnt_q, skp_cnt_d;
    logic          link_idle_q, link_idle_d, dllp_q, dllp_d;
    logic          pv_q, pv_d, sop_q, sop_d, eop_q, eop_d, abort_q, abort_d;
    logic [7:0]    pd_q, pd_d;
    logic          skp_os_q, skp_os_d, fts_q, fts_d, ferr_q, ferr_d;
    logic          emit, emit_eop, emit_abort, idle_proc;

    always_comb begin
        state_d     = state_q;
        hold_d      = hold_q;
        hold_full_d = hold_full_q;
        first_d     = first_q;
        len_d       = len_q;
        skp_d       = skp_q;
        link_idle_d = link_idle_q;
        dllp_d      = dllp_q;
        skp_cnt_d   = 3'd0;
        skp_os_d    = 1'b0;
        fts_d       = 1'b0;
        ferr_d      = 1'b0;
        emit        = 1'b0;
        emit_eop    = 1'b0;
        emit_abort  = 1'b0;
        idle_proc   = 1'b0;
        lim         = (state_q == S_DLLP) ? DLLP_LIM : TLP_LIM;
        if (sym_valid) begin
            case (state_q)
                S_OS: begin
                    if (sym_type == T_SKP) begin
                        skp_d = (skp_q == 3'd7) ? skp_q : skp_q + 3'd1;
                    end else if (sym_type == T_FTS) begin
                        fts_d = 1'b1;
                    end else begin
                        // Set closes; the terminating symbol is then handled as in IDLE.
                        skp_os_d  = (skp_q != 3'd0);
                        skp_cnt_d = skp_q;
                        skp_d     = 3'd0;
                        idle_proc = 1'b1;
                    end
                end
                S_TLP, S_DLLP: begin
                    link_idle_d = 1'b0;
                    case (sym_type)
                        T_DATA: begin
                            if (len_q == lim) begin
                                emit       = hold_full_q;
                                emit_eop   = 1'b1;
                                emit_abort = 1'b1;
                                ferr_d     = 1'b1;
                                state_d    = S_IDLE;
                            end else begin
                                emit        = hold_full_q;
                                hold_d      = sym_data;
                                hold_full_d = 1'b1;
                                len_d       = len_q + LW'(1);
                            end
                        end
                        T_END: begin
                            state_d = S_IDLE;
                            if (len_q == '0) begin
                                ferr_d = 1'b1;
                            end else begin
                                emit     = 1'b1;
                                emit_eop = 1'b1;
                                if (state_q == S_DLLP && len_q != DLLP_LIM) begin
                                    emit_abort = 1'b1;
                                    ferr_d     = 1'b1;
                                end
                            end
                        end
                        T_EDB: begin
                            state_d    = S_IDLE;
                            ferr_d     = (len_q == '0);
                            emit       = (len_q != '0);
                            emit_eop   = 1'b1;
                            emit_abort = 1'b1;
                        end
                        default: begin
                            emit       = hold_full_q;
                            emit_eop   = 1'b1;
                            emit_abort = 1'b1;
                            ferr_d     = 1'b1;
                            skp_d      = 3'd0;
                            state_d    = (sym_type == T_COM) ? S_OS : S_IDLE;
                        end
                    endcase
                end
                default: idle_proc = 1'b1;
            endcase

            if (idle_proc) begin
                case (sym_type)
                    T_STP, T_SDP: begin
                        state_d     = (sym_type == T_SDP) ? S_DLLP : S_TLP;
                        dllp_d      = (sym_type == T_SDP);
                        len_d       = '0;
                        hold_full_d = 1'b0;
                        first_d     = 1'b1;
                        link_idle_d = 1'b0;
                    end
                    T_COM: begin
                        state_d     = S_OS;
                        skp_d       = 3'd0;
                        link_idle_d = 1'b0;
                    end
                    T_IDL: begin
                        state_d     = S_IDLE;
                        link_idle_d = 1'b1;
                    end
                    T_PAD: state_d = S_IDLE;
                    default: begin
                        state_d     = S_IDLE;
                        ferr_d      = 1'b1;
                        link_idle_d = 1'b0;
                    end
                endcase
            end
        end

        pv_d    = emit;
        pd_d    = emit ? hold_q : 8'd0;
        sop_d   = emit && first_q;
        eop_d   = emit && emit_eop;
        abort_d = emit && emit_abort;
        if (emit) first_d = 1'b0;
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q     <= S_IDLE;
            hold_q      <= 8'd0;
            hold_full_q <= 1'b0;
            first_q     <= 1'b0;
            len_q       <= '0;
            skp_q       <= 3'd0;
            skp_cnt_q   <= 3'd0;
            link_idle_q <= 1'b0;
            dllp_q      <= 1'b0;
            pv_q        <= 1'b0;
            pd_q        <= 8'd0;
            sop_q       <= 1'b0;
            eop_q       <= 1'b0;
            abort_q     <= 1'b0;
            skp_os_q    <= 1'b0;
            fts_q       <= 1'b0;
            ferr_q      <= 1'b0;
        end else begin
            state_q     <= state_d;
            hold_q      <= hold_d;
            hold_full_q <= hold_full_d;
            first_q     <= first_d;
            len_q       <= len_d;
            skp_q       <= skp_d;
            skp_cnt_q   <= skp_cnt_d;
            link_idle_q <= link_idle_d;
            dllp_q      <= dllp_d;
            pv_q        <= pv_d;
            pd_q        <= pd_d;
            sop_q       <= sop_d;
            eop_q       <= eop_d;
            abort_q     <= abort_d;
            skp_os_q    <= skp_os_d;
            fts_q       <= fts_d;
            ferr_q      <= ferr_d;
        end
    end

    assign pkt_valid = pv_q;
    assign pkt_data  = pd_q;
    assign pkt_sop   = sop_q;
    assign pkt_eop   = eop_q;
    assign pkt_abort = abort_q;
    assign pkt_dllp  = dllp_q;
    assign skp_os    = skp_os_q;
    assign skp_count = skp_cnt_q;
    assign fts_seen  = fts_q;
    assign frame_err = ferr_q;
    assign link_idle = link_idle_q;

`ifdef FRAMING_CTRL_STATS_EN
    logic [15:0] good_q, good_d, bad_q, bad_d;

    // A coincident abort and frame_err is one bad event.
    always_comb begin
        good_d = good_q;
        bad_d  = bad_q;
        if (eop_d && !abort_d && good_q != 16'hFFFF) good_d = good_q + 16'd1;
        if ((abort_d || ferr_d) && bad_q != 16'hFFFF) bad_d = bad_q + 16'd1;
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            good_q <= 16'd0;
            bad_q  <= 16'd0;
        end else begin
            good_q <= good_d;
            bad_q  <= bad_d;
        end
    end

    assign good_cnt = good_q;
    assign bad_cnt  = bad_q;
`else
    assign good_cnt = 16'd0;
    assign bad_cnt  = 16'd0;
`endif
endmodule

// File: tb/tb_framing_ctrl.sv
// Bench for framing_ctrl: directed test-plan sequences then random symbols,
// all checked cycle by cycle against a queue-based packet model.
module tb_framing_ctrl;
    localparam int MAXL = 64;
    localparam int DL   = 6;
    localparam logic [3:0] K_DATA = 4'd0, K_COM = 4'd1, K_PAD = 4'd2, K_SKP = 4'd3,
                           K_STP  = 4'd4, K_SDP = 4'd5, K_END = 4'd6, K_EDB = 4'd7,
                           K_FTS  = 4'd8, K_IDL = 4'd9;
    localparam int MD_IDLE = 0, MD_TLP = 1, MD_DLLP = 2, MD_OS = 3;

    logic        clk = 1'b0, reset = 1'b1, sym_valid = 1'b0;
    logic [3:0]  sym_type = 4'd0;
    logic [7:0]  sym_data = 8'd0;
    logic        pkt_valid, pkt_sop, pkt_eop, pkt_abort, pkt_dllp;
    logic [7:0]  pkt_data;
    logic        skp_os, fts_seen, frame_err, link_idle;
    logic [2:0]  skp_count;
    logic [15:0] good_cnt, bad_cnt;

    framing_ctrl #(.MAX_LEN(MAXL), .DLLP_LEN(DL)) dut (
        .clk(clk), .reset(reset), .sym_valid(sym_valid), .sym_type(sym_type),
        .sym_data(sym_data), .pkt_valid(pkt_valid), .pkt_data(pkt_data),
        .pkt_sop(pkt_sop), .pkt_eop(pkt_eop), .pkt_abort(pkt_abort),
        .pkt_dllp(pkt_dllp), .skp_os(skp_os), .skp_count(skp_count),
        .fts_seen(fts_seen), .frame_err(frame_err), .link_idle(link_idle),
        .good_cnt(good_cnt), .bad_cnt(bad_cnt)
    );

    always #5 clk = ~clk;

    int vectors = 0, miscompares = 0, beats = 0;

    // Reference model: packet bytes collected in a queue, ordered-set SKP tally.
    int         m_mode, m_skps, m_good, m_bad;
    logic [7:0] m_q[$];
    bit         m_li, m_dllp;
    bit         e_v, e_sop, e_eop, e_abort, e_ferr, e_skpos, e_fts;
    logic [7:0] e_data;
    logic [2:0] e_skpcnt;

    task chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s: observed %0h, expected %0h", tag, obs, exp);
        end
    endtask

    task m_clear_exp();
        e_v = 0; e_sop = 0; e_eop = 0; e_abort = 0; e_ferr = 0; e_skpos = 0; e_fts = 0;
        e_data = 8'd0; e_skpcnt = 3'd0;
    endtask

    task m_reset();
        m_mode = MD_IDLE; m_skps = 0; m_good = 0; m_bad = 0;
        m_q.delete(); m_li = 0; m_dllp = 0;
        m_clear_exp();
    endtask

    // Last byte collected so far leaves the pipeline, closing the packet if eop.
    task m_emit(input bit eop, input bit ab);
        if (m_q.size() > 0) begin
            e_v = 1; e_data = m_q[m_q.size()-1]; e_sop = (m_q.size() == 1);
            e_eop = eop; e_abort = ab;
        end
    endtask

    task m_idle_rules(input logic [3:0] t);
        case (t)
            K_STP, K_SDP: begin m_mode = (t == K_SDP) ? MD_DLLP : MD_TLP; m_dllp = (t == K_SDP); m_q.delete(); m_li = 0; end
            K_COM:   begin m_mode = MD_OS; m_skps = 0; m_li = 0; end
            K_IDL:   begin m_mode = MD_IDLE; m_li = 1; end
            K_PAD:   m_mode = MD_IDLE;
            default: begin m_mode = MD_IDLE; e_ferr = 1; m_li = 0; end
        endcase
    endtask

    task m_sym(input logic [3:0] t, input logic [7:0] d);
        int lim;
        bit good;
        m_clear_exp();
        lim = (m_mode == MD_DLLP) ? DL : MAXL;
        if (m_mode == MD_OS) begin
            if (t == K_SKP) m_skps = (m_skps < 7) ? m_skps + 1 : 7;
            else if (t == K_FTS) e_fts = 1;
            else begin
                if (m_skps > 0) begin e_skpos = 1; e_skpcnt = 3'(m_skps); end
                m_skps = 0;
                m_idle_rules(t);
            end
        end else if (m_mode == MD_TLP || m_mode == MD_DLLP) begin
            m_li = 0;
            if (t == K_DATA && m_q.size() < lim) begin
                m_emit(0, 0);
                m_q.push_back(d);
            end else begin
                if (t == K_DATA) begin m_emit(1, 1); e_ferr = 1; end
                else if (t == K_END) begin
                    good = !m_dllp || m_q.size() == DL;
                    if (m_q.size() == 0) e_ferr = 1;
                    else begin m_emit(1, !good); e_ferr = !good; end
                end else if (t == K_EDB) begin
                    if (m_q.size() == 0) e_ferr = 1; else m_emit(1, 1);
                end else begin
                    m_emit(1, 1); e_ferr = 1;
                end
                m_mode = (t == K_COM) ? MD_OS : MD_IDLE;
                if (t == K_COM) m_skps = 0;
                m_q.delete();
            end
        end else m_idle_rules(t);
        if (e_v && e_eop && !e_abort && m_good < 16'hFFFF) m_good++;
        if (((e_v && e_abort) || e_ferr) && m_bad < 16'hFFFF) m_bad++;
    endtask

    task check_outputs();
        if (pkt_valid) beats++;
        chk("pkt_valid", pkt_valid, e_v);
        if (e_v) begin
            chk("pkt_data", pkt_data, e_data);
            chk("pkt_sop", pkt_sop, e_sop);
            chk("pkt_eop", pkt_eop, e_eop);
            chk("pkt_abort", pkt_abort, e_abort);
            chk("pkt_dllp", pkt_dllp, m_dllp);
        end
        chk("frame_err", frame_err, e_ferr);
        chk("skp_os", skp_os, e_skpos);
        if (e_skpos) chk("skp_count", skp_count, e_skpcnt);
        chk("fts_seen", fts_seen, e_fts);
        chk("link_idle", link_idle, m_li);
`ifdef FRAMING_CTRL_STATS_EN
        chk("good_cnt", good_cnt, 16'(m_good));
        chk("bad_cnt", bad_cnt, 16'(m_bad));
`else
        chk("good_cnt", good_cnt, 16'd0);
        chk("bad_cnt", bad_cnt, 16'd0);
`endif
    endtask

    task step(input logic [3:0] t, input logic [7:0] d);
        sym_valid = 1; sym_type = t; sym_data = d;
        @(posedge clk); #1;
        m_sym(t, d);
        check_outputs();
        sym_valid = 0;
    endtask

    task gap();
        sym_valid = 0; sym_type = 4'($urandom); sym_data = 8'($urandom);
        @(posedge clk); #1;
        m_clear_exp();
        check_outputs();
    endtask

    task rand_sym();
        int r;
        logic [3:0] t;
        r = $urandom_range(0, 99);
        if (r < 45) t = K_DATA;
        else if (r < 52) t = K_STP;
        else if (r < 57) t = K_SDP;
        else if (r < 67) t = K_END;
        else if (r < 70) t = K_EDB;
        else if (r < 75) t = K_COM;
        else if (r < 82) t = K_SKP;
        else if (r < 85) t = K_FTS;
        else if (r < 92) t = K_IDL;
        else if (r < 95) t = K_PAD;
        else t = 4'($urandom_range(10, 15));
        step(t, 8'($urandom));
    endtask

    initial begin
        int b0;
        m_reset();
        #12;
        check_outputs();
        @(negedge clk) reset = 0;

        // Three-byte TLP
        b0 = beats;
        step(K_STP, 0); step(K_DATA, 8'h11); step(K_DATA, 8'h22); step(K_DATA, 8'h33);
        step(K_END, 0); step(K_IDL, 0);
        chk("tlp3_beats", 16'(beats - b0), 16'd3);

        // Clean DLLP, then a short one
        step(K_SDP, 0);
        for (int i = 0; i < DL; i++) step(K_DATA, 8'(8'hD0 + i));
        step(K_END, 0);
        step(K_SDP, 0);
        for (int i = 0; i < DL - 1; i++) step(K_DATA, 8'(8'hE0 + i));
        step(K_END, 0); gap();

        // EDB-nullified single byte
        step(K_STP, 0); step(K_DATA, 8'hAA); step(K_EDB, 0); gap();

        // TLP overflow
        b0 = beats;
        step(K_STP, 0);
        for (int i = 0; i < MAXL + 1; i++) step(K_DATA, 8'(i));
        step(K_IDL, 0);
        chk("ovf_beats", 16'(beats - b0), 16'(MAXL));

        // Ordered sets
        step(K_COM, 0); step(K_SKP, 0); step(K_SKP, 0); step(K_SKP, 0); step(K_IDL, 0); gap();
        step(K_COM, 0); step(K_FTS, 0); step(K_FTS, 0); step(K_IDL, 0);

        // Reset mid-packet
        step(K_STP, 0); step(K_DATA, 8'h11); step(K_DATA, 8'h22);
        #2 reset = 1;
        #1;
        m_reset();
        check_outputs();
        @(negedge clk) reset = 0;
        step(K_END, 0);

        for (int i = 0; i < 4000; i++) begin
            if ($urandom_range(0, 99) < 12) gap();
            else rand_sym();
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule
